// File: rtl/cycle_sequencer_if.sv
// ============================================================================
// Module   : cycle_sequencer_if
// Brief    : Control/handshake bundle between the cycle sequencer and datapath.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface cycle_sequencer_if #(
    parameter int OPW = 4
);
    logic           run;
    logic [OPW-1:0] opcode;
    logic           branch_taken;
    logic           mem_ready;
    logic           mem_req;
    logic           mem_we;
    logic           pc_en;
    logic           ir_en;
    logic           opnd_en;
    logic           alu_en;
    logic           mdr_en;
    logic           rf_we;
    logic           halted;
    logic           fault;
    logic [2:0]     state;

    modport master (
        input  run, opcode, branch_taken, mem_ready,
        output mem_req, mem_we, pc_en, ir_en, opnd_en, alu_en, mdr_en,
               rf_we, halted, fault, state
    );

    modport slave (
        output run, opcode, branch_taken, mem_ready,
        input  mem_req, mem_we, pc_en, ir_en, opnd_en, alu_en, mdr_en,
               rf_we, halted, fault, state
    );
endinterface

`default_nettype wire

// File: rtl/cycle_sequencer.sv
// ============================================================================
// Module   : cycle_sequencer
// Brief    : Multicycle control FSM: register enables, memory handshake, timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cycle_sequencer #(
    parameter int OPW        = 4,
    parameter int WAIT_LIMIT = 15,
    parameter int CNTW       = 4
) (
    input wire clk,
    input wire reset,
    cycle_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALTED    = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    localparam logic [OPW-1:0]  c_OP_LOAD    = OPW'(8);
    localparam logic [OPW-1:0]  c_OP_STORE   = OPW'(9);
    localparam logic [OPW-1:0]  c_OP_BR0     = OPW'(10);
    localparam logic [OPW-1:0]  c_OP_BR1     = OPW'(11);
    localparam logic [OPW-1:0]  c_OP_HALT    = '1;
    localparam logic [CNTW-1:0] c_WAIT_LIMIT = CNTW'(WAIT_LIMIT);
    localparam bit              c_TIMEOUT_EN = (WAIT_LIMIT > 0);

    state_t          r_state;
    state_t          w_next;
    logic [CNTW-1:0] r_cnt;
    logic [CNTW-1:0] w_cnt_next;

    logic w_is_load;
    logic w_is_store;
    logic w_is_branch;
    logic w_is_halt;
    logic w_wait_state;
    logic w_timeout;

    logic w_mem_req;
    logic w_mem_we;
    logic w_pc_en;
    logic w_ir_en;
    logic w_opnd_en;
    logic w_alu_en;
    logic w_mdr_en;
    logic w_rf_we;
    logic w_halted;
    logic w_fault;

    assign w_is_load    = (bus.opcode == c_OP_LOAD);
    assign w_is_store   = (bus.opcode == c_OP_STORE);
    assign w_is_branch  = (bus.opcode == c_OP_BR0) || (bus.opcode == c_OP_BR1);
    assign w_is_halt    = (bus.opcode == c_OP_HALT);
    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMORY);

    // The limit cycle still completes normally if the memory answers in it.
    assign w_timeout = c_TIMEOUT_EN && w_wait_state && !bus.mem_ready &&
                       (r_cnt == c_WAIT_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_cnt_next = '0;
        if (w_wait_state && !bus.mem_ready && (w_next == r_state)) begin
            w_cnt_next = r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_mem_req = 1'b0;
        w_mem_we  = 1'b0;
        w_pc_en   = 1'b0;
        w_ir_en   = 1'b0;
        w_opnd_en = 1'b0;
        w_alu_en  = 1'b0;
        w_mdr_en  = 1'b0;
        w_rf_we   = 1'b0;
        w_halted  = 1'b0;
        w_fault   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.run) w_next = S_FETCH;
            end
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_en = 1'b1;
                    w_pc_en = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                w_opnd_en = 1'b1;
                w_next    = w_is_halt ? S_HALTED : S_EXECUTE;
            end
            S_EXECUTE: begin
                w_alu_en = 1'b1;
                if (w_is_branch) begin
                    w_pc_en = bus.branch_taken;
                    w_next  = bus.run ? S_FETCH : S_IDLE;
                end else if (w_is_load || w_is_store) begin
                    w_next = S_MEMORY;
                end else begin
                    w_next = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                // Only LOAD/STORE reach here, so "not a store" means load.
                w_mem_req = 1'b1;
                w_mem_we  = w_is_store;
                if (bus.mem_ready) begin
                    if (w_is_store) begin
                        w_next = bus.run ? S_FETCH : S_IDLE;
                    end else begin
                        w_mdr_en = 1'b1;
                        w_next   = S_WRITEBACK;
                    end
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_WRITEBACK: begin
                w_rf_we = 1'b1;
                w_next  = bus.run ? S_FETCH : S_IDLE;
            end
            S_HALTED: begin
                w_halted = 1'b1;
            end
            S_FAULT: begin
                w_fault = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    assign bus.mem_req = w_mem_req;
    assign bus.mem_we  = w_mem_we;
    assign bus.pc_en   = w_pc_en;
    assign bus.ir_en   = w_ir_en;
    assign bus.opnd_en = w_opnd_en;
    assign bus.alu_en  = w_alu_en;
    assign bus.mdr_en  = w_mdr_en;
    assign bus.rf_we   = w_rf_we;
    assign bus.halted  = w_halted;
    assign bus.fault   = w_fault;
    assign bus.state   = r_state;

endmodule

`default_nettype wire
